// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width shared by the serial adder slice
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle (start,a,b,cin in; busy,done,sum,cout out) with master/slave modports
interface serial_adder_if import serial_adder_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_add1bit.sv
// add1bit: 1-bit full adder cell; A,B,Cin in, Y sum and Cout carry out
module add1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);
  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder; clk, rst (sync, active-high), bus = start/a/b/cin in, busy/done/sum/cout out
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             y;
  logic             co;
  logic             last;
  add1bit u_fa (.A(shift_a[0]), .B(shift_b[0]), .Cin(carry_q), .Y(y), .Cout(co));
  assign last     = cnt == CW'(WIDTH - 1);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      psum    <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          shift_a <= bus.a;
          shift_b <= bus.b;
          carry_q <= bus.cin;
          psum    <= '0;
          cnt     <= '0;
          busy_q  <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          psum    <= {y, psum[WIDTH-1:1]};
          carry_q <= co;
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          cnt     <= last ? cnt : cnt + 1'b1;
          if (last) begin
            sum_q  <= {y, psum[WIDTH-1:1]};
            cout_q <= co;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table, corner sequences and back-to-back random sums for WIDTH 2, 8 and 16
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(2))  i2();
  serial_adder_if #(.WIDTH(8))  i8();
  serial_adder_if #(.WIDTH(16)) i16();
  serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2.slave));
  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t tv[8];
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction
  task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
    if (w == 2) begin
      i2.a = a[1:0]; i2.b = b[1:0]; i2.cin = c; i2.start = 1'b1;
    end else if (w == 8) begin
      i8.a = a[7:0]; i8.b = b[7:0]; i8.cin = c; i8.start = 1'b1;
    end else begin
      i16.a = a[15:0]; i16.b = b[15:0]; i16.cin = c; i16.start = 1'b1;
    end
  endtask
  function automatic logic done_of(input int w);
    return w == 2 ? i2.done : w == 8 ? i8.done : i16.done;
  endfunction
  function automatic logic [63:0] res_of(input int w);
    return w == 2 ? 64'({i2.cout, i2.sum}) : w == 8 ? 64'({i8.cout, i8.sum}) : 64'({i16.cout, i16.sum});
  endfunction
  task automatic b2b(input int w, input int n);
    logic [63:0] m, ra, rb, ex;
    logic rc;
    int gap;
    m = (64'd1 << w) - 64'd1;
    @(negedge clk);
    ra = {$urandom, $urandom} & m;
    rb = {$urandom, $urandom} & m;
    rc = 1'($urandom);
    drive(w, ra, rb, rc);
    for (int k = 0; k < n; k++) begin
      ex = ra + rb + 64'(rc);
      @(negedge clk);
      gap = 1;
      while (!done_of(w) && gap < w + 8) begin
        @(negedge clk);
        gap++;
      end
      chk("b2b_sum", res_of(w), ex);
      chk("b2b_gap", 64'(gap), 64'(k == 0 ? w + 1 : w + 2));
      ra = {$urandom, $urandom} & m;
      rb = {$urandom, $urandom} & m;
      rc = 1'($urandom);
      drive(w, ra, rb, rc);
    end
    i2.start = 1'b0; i8.start = 1'b0; i16.start = 1'b0;
    repeat (w + 4) @(negedge clk);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] hs, input logic hc,
                     output logic [7:0] s, output logic co, output int lat, output int bc, output logic held);
    @(negedge clk);
    i8.a = a; i8.b = b; i8.cin = c; i8.start = 1'b1;
    bc = 0;
    held = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    i8.a = ~a;
    i8.b = ~b;
    lat = 1;
    while (!i8.done && lat < 20) begin
      bc += int'(i8.busy);
      held &= (i8.sum == hs) && (i8.cout == hc);
      @(negedge clk);
      lat++;
    end
    bc += int'(i8.busy);
    s = i8.sum;
    co = i8.cout;
  endtask
  initial begin
    logic [7:0] s, ps;
    logic co, pc, held;
    int lat, bc, nd;
    tv[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tv[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tv[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tv[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv[7] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
    i2.start = 1'b0; i2.a = '0; i2.b = '0; i2.cin = 1'b0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    i16.start = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(i8.busy), 64'd0);
    chk("rst_done", 64'(i8.done), 64'd0);
    chk("rst_res", 64'({i8.cout, i8.sum}), 64'd0);
    ps = 8'h00;
    pc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op8(tv[i].a, tv[i].b, tv[i].c, ps, pc, s, co, lat, bc, held);
      chk("tbl_sum", 64'(s), 64'(tv[i].s));
      chk("tbl_cout", 64'(co), 64'(tv[i].co));
      chk("tbl_latency", 64'(lat), 64'd9);
      chk("tbl_busy_cycles", 64'(bc), 64'd9);
      chk("tbl_hold", 64'(held), 64'd1);
      @(negedge clk);
      chk("tbl_idle_after", 64'({i8.busy, i8.done}), 64'd0);
      ps = tv[i].s;
      pc = tv[i].co;
    end
    @(negedge clk);
    i8.a = 8'h12; i8.b = 8'h34; i8.cin = 1'b0; i8.start = 1'b1;
    nd = 0;
    s = 8'h00;
    co = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin
        i8.a = 8'hFF;
        i8.b = 8'hFF;
      end
      if (i8.done) begin
        nd++;
        s = i8.sum;
        co = i8.cout;
      end
      i8.start = (k == 3) || i8.done;
    end
    i8.start = 1'b0;
    chk("ign_done_count", 64'(nd), 64'd1);
    chk("ign_sum", 64'(s), 64'h46);
    chk("ign_cout", 64'(co), 64'd0);
    chk("ign_idle", 64'(i8.busy), 64'd0);
    @(negedge clk);
    i8.a = 8'hF0; i8.b = 8'h0F; i8.cin = 1'b0; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(i8.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(i8.busy), 64'd0);
    chk("abort_res", 64'({i8.cout, i8.sum}), 64'd0);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      nd += int'(i8.done);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op8(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, s, co, lat, bc, held);
    chk("post_abort_sum", 64'({co, s}), 64'h002);
    chk("post_abort_lat", 64'(lat), 64'd9);
    chk("post_abort_hold", 64'(held), 64'd1);
    b2b(8, 1000);
    b2b(2, 200);
    b2b(16, 200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
